// File: rtl/kbd_voice_alloc.sv
// kbd_voice_alloc: polyphonic voice allocator for the piano-key bitmask.
// Synchronises the key-held mask and detects press/release edges.
// A scan then walks the keys one per clock and assigns or releases synth voices.
// A press with no free voice steals voices in round-robin order.
// Optional build macro KBD_SUSTAIN_EN adds a sustain pedal input.
// When the pedal is down, releases are held until the pedal lifts.
module kbd_voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int NUM_KEYS   = 13
) (
  input  logic                    clk,
  input  logic                    ar,
  input  logic [NUM_KEYS-1:0]     keys_in,
  input  logic [1:0]              octave,
`ifdef KBD_SUSTAIN_EN
  input  logic                    sustain,
`endif
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [4*NUM_VOICES-1:0] voice_note,
  output logic [2*NUM_VOICES-1:0] voice_oct,
  output logic [NUM_VOICES-1:0]   voice_trig,
  output logic                    steal,
  output logic                    busy
);

  localparam int VP_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t              state, state_nxt;
  logic [NUM_KEYS-1:0] s1, s2;
  logic [NUM_KEYS-1:0] prev;
  logic [NUM_KEYS-1:0] on_m, off_m;
  logic [3:0]          idx;
  logic [VP_W-1:0]     steal_ptr;
  logic                scan_start;
  logic                scan_on, scan_off;
  logic                free_found;
  logic [VP_W-1:0]     free_v;
  logic [VP_W-1:0]     alloc_v;

`ifdef KBD_SUSTAIN_EN
  logic [NUM_VOICES-1:0] sus;
  logic                  sustain_q;
  logic                  sus_fall;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (ar) state <= IDLE;
    else    state <= state_nxt;
  end

  // Next-state: a mask change in IDLE starts a full scan of all keys
  always_comb begin
    state_nxt  = state;
    scan_start = 1'b0;
    case (state)
      IDLE: begin
        if (s2 != prev) begin
          scan_start = 1'b1;
          state_nxt  = SCAN;
        end
      end
      SCAN: begin
        if (idx == 4'(NUM_KEYS - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SCAN);

  // Two-flop synchroniser, edge masks latched at scan start, and the scan index.
  // prev moves only at scan start, so changes that arrive mid-scan stay visible afterwards.
  always_ff @(posedge clk) begin
    if (ar) begin
      s1    <= '0;
      s2    <= '0;
      prev  <= '0;
      on_m  <= '0;
      off_m <= '0;
      idx   <= '0;
    end else begin
      s1 <= keys_in;
      s2 <= s1;
      if (scan_start) begin
        on_m  <= s2 & ~prev;
        off_m <= ~s2 & prev;
        prev  <= s2;
        idx   <= '0;
      end else if (state == SCAN) begin
        idx <= idx + 4'd1;
      end
    end
  end

  assign scan_on  = (state == SCAN) && on_m[idx];
  assign scan_off = (state == SCAN) && off_m[idx];

  // Lowest-index voice whose gate is down (sustained voices keep gate high)
  always_comb begin
    free_found = 1'b0;
    free_v     = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!voice_gate[v]) begin
        free_found = 1'b1;
        free_v     = VP_W'(v);
      end
    end
  end

  assign alloc_v = free_found ? free_v : steal_ptr;

`ifdef KBD_SUSTAIN_EN
  // Registered copy of the pedal for falling-edge detection
  always_ff @(posedge clk) begin
    if (ar) sustain_q <= 1'b0;
    else    sustain_q <= sustain;
  end

  assign sus_fall = sustain_q & ~sustain;
`endif

  // Voice bank update: pedal release first, then key release, then allocation.
  // Allocation is last so it wins on the chosen voice.
  always_ff @(posedge clk) begin
    if (ar) begin
      voice_gate <= '0;
      voice_note <= '0;
      voice_oct  <= '0;
      voice_trig <= '0;
      steal      <= 1'b0;
      steal_ptr  <= '0;
`ifdef KBD_SUSTAIN_EN
      sus        <= '0;
`endif
    end else begin
      voice_trig <= '0;
      steal      <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
`ifdef KBD_SUSTAIN_EN
        if (sus_fall && sus[v]) begin
          voice_gate[v] <= 1'b0;
          sus[v]        <= 1'b0;
        end
`endif
        if (scan_off && voice_gate[v] && (voice_note[4*v +: 4] == idx)) begin
`ifdef KBD_SUSTAIN_EN
          if (sustain) begin
            sus[v] <= 1'b1;
          end else begin
            voice_gate[v] <= 1'b0;
            sus[v]        <= 1'b0;
          end
`else
          voice_gate[v] <= 1'b0;
`endif
        end
      end
      if (scan_on) begin
        voice_gate[alloc_v]          <= 1'b1;
        voice_note[4*alloc_v +: 4]   <= idx;
        voice_oct[2*alloc_v +: 2]    <= octave;
        voice_trig[alloc_v]          <= 1'b1;
`ifdef KBD_SUSTAIN_EN
        sus[alloc_v]                 <= 1'b0;
`endif
        if (!free_found) begin
          steal     <= 1'b1;
          steal_ptr <= (steal_ptr == VP_W'(NUM_VOICES - 1)) ? '0 : steal_ptr + 1'b1;
        end
      end
    end
  end

endmodule
